// File: rtl/loader_pkg.sv
// Shared constants and FSM state type for the instruction loader.
// LOADER_CHKSUM_EN enables the running XOR checksum of loaded bytes.
package loader_pkg;

    localparam logic [7:0] START_BYTE = 8'hFE;
    localparam logic [7:0] END_BYTE   = 8'hFF;
    localparam int         DEF_IMEM_DEPTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/instr_byte_packer.sv
// Byte index counter and shift register that assembles big-endian words.
// word_o is the complete word while word_valid_o is high (4th byte present).
module instr_byte_packer (
    input  logic        clk_i,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    output logic [1:0]  byte_idx_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] shift_q, shift_d;

    always_comb begin
        idx_d   = idx_q;
        shift_d = shift_q;
        if (clear_i) begin
            idx_d   = 2'd0;
            shift_d = 24'd0;
        end else if (byte_en_i) begin
            // index wraps 3 -> 0 after the word completes
            idx_d   = idx_q + 2'd1;
            shift_d = {shift_q[15:0], byte_i};
        end
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            idx_q   <= 2'd0;
            shift_q <= 24'd0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    assign byte_idx_o   = idx_q;
    assign word_valid_o = byte_en_i && !clear_i && (idx_q == 2'd3);
    assign word_o       = {shift_q, byte_i};

endmodule

// File: rtl/instr_loader.sv
// Loads a framed byte stream into instruction memory, then releases the CPU.
// Optional LOADER_CHKSUM_EN adds an XOR checksum of accepted data bytes.
module instr_loader
    import loader_pkg::*;
#(
    parameter int IMEM_DEPTH = DEF_IMEM_DEPTH,
    parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic [7:0]        instr_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_data_o,
    output logic              load_done_o,
    output logic              cpu_start_o,
    output logic [ADDR_W:0]   word_count_o,
    output logic [7:0]        chksum_o
);

    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(IMEM_DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              start_q, start_d;

    logic        pk_clear;
    logic        pk_en;
    logic [1:0]  pk_idx;
    logic        pk_valid;
    logic [31:0] pk_word;

    instr_byte_packer u_packer (
        .clk_i        (clk_i),
        .reset        (reset),
        .clear_i      (pk_clear),
        .byte_en_i    (pk_en),
        .byte_i       (instr_i),
        .byte_idx_o   (pk_idx),
        .word_valid_o (pk_valid),
        .word_o       (pk_word)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        start_d  = 1'b0;
        pk_clear = 1'b0;
        pk_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (instr_i == START_BYTE) begin
                    state_d  = LOAD;
                    cnt_d    = '0;
                    pk_clear = 1'b1;
                end
            end
            LOAD: begin
                // end marker only counts at a word boundary
                if (pk_idx == 2'd0 && instr_i == END_BYTE) begin
                    state_d = DONE;
                    start_d = 1'b1;
                end else begin
                    pk_en = 1'b1;
                    if (pk_valid) begin
                        we_d   = 1'b1;
                        addr_d = cnt_q[ADDR_W-1:0];
                        data_d = pk_word;
                        cnt_d  = cnt_q + (ADDR_W+1)'(1);
                        if (cnt_q == LAST_WORD) begin
                            state_d = DONE;
                            start_d = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            start_q <= start_d;
        end
    end

`ifdef LOADER_CHKSUM_EN
    logic [7:0] ck_q, ck_d;

    assign ck_d = pk_en ? (ck_q ^ instr_i) : ck_q;

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            ck_q <= 8'h00;
        end else begin
            ck_q <= ck_d;
        end
    end

    assign chksum_o = ck_q;
`else
    assign chksum_o = 8'h00;
`endif

    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_data_o  = data_q;
    assign load_done_o  = (state_q == DONE);
    assign cpu_start_o  = start_q;
    assign word_count_o = cnt_q;

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 64, number of 32-bit instruction words.
REQ-002 SHALL have parameter ADDR_W, default 6, equal to log2(IMEM_DEPTH).
REQ-003 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port instr_i  input  8  instruction byte stream, one byte sampled per cycle.
REQ-006 SHALL have port imem_we_o  output  1  instruction-memory write strobe.
REQ-007 SHALL have port imem_addr_o  output  ADDR_W  word write address.
REQ-008 SHALL have port imem_data_o  output  32  assembled instruction word.
REQ-009 SHALL have port load_done_o  output  1  level, high once loading has finished.
REQ-010 SHALL have port cpu_start_o  output  1  one-cycle pulse releasing the downstream CPU.
REQ-011 SHALL have port word_count_o  output  ADDR_W+1  number of words written so far.
REQ-012 SHALL have port chksum_o  output  8  running XOR of loaded data bytes (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, DONE.
REQ-014 In IDLE, SHALL ignore every byte except 8'hFE (start), which moves the FSM to LOAD with byte index 0 and word index 0.
REQ-015 In LOAD, SHALL pack bytes big-endian: 1st byte -> [31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0].
REQ-016 SHALL recognise 8'hFF as the end marker only at byte index 0; at index 1..3, 8'hFF and 8'hFE are ordinary data.
REQ-017 Consequence: a word whose MSB byte is 8'hFF cannot be loaded; this is a protocol constraint on the loader.
REQ-018 On the edge that samples the 4th byte, SHALL register imem_we_o=1, imem_addr_o=word index, imem_data_o=packed word, for exactly one cycle.
REQ-019 After each write, SHALL increment word index and word_count_o and return byte index to 0.
REQ-020 On the end marker, SHALL enter DONE and issue no write.
REQ-021 When word IMEM_DEPTH-1 is written, SHALL enter DONE on that same edge; no address wrap-around.
REQ-022 On entering DONE, SHALL pulse cpu_start_o for exactly one cycle; load_done_o SHALL rise on the same edge and stay high.
REQ-023 DONE is terminal until reset: all bytes, including 8'hFE, are ignored, and no writes occur.
REQ-024 imem_we_o SHALL be 0 in every cycle except those defined in REQ-018.
REQ-025 imem_addr_o and imem_data_o SHALL hold their last written values when imem_we_o=0.

Reset
REQ-026 Asserting reset SHALL, asynchronously and at any time (mid-word included), force IDLE and clear byte index, word index, the partial word, and the checksum.
REQ-027 While reset is asserted, SHALL drive imem_we_o=0, imem_addr_o=0, imem_data_o=0, load_done_o=0, cpu_start_o=0, word_count_o=0, chksum_o=0.
REQ-028 SHALL not erase memory contents written before reset.
REQ-029 SHALL discard any partial word.

Configuration
REQ-030 Macro LOADER_CHKSUM_EN defined: chksum_o SHALL XOR in every data byte accepted in LOAD, excluding start and end markers, and update on the same edge the byte is sampled.
REQ-031 Macro undefined: chksum_o SHALL be constant 8'h00, and no checksum register SHALL be synthesised.

Structure
REQ-032 Package loader_pkg SHALL hold START_BYTE=8'hFE, END_BYTE=8'hFF, the default IMEM_DEPTH, and the FSM state typedef.
REQ-033 Sub-module instr_byte_packer (byte index counter plus 32-bit shift register, with a word_valid output) SHALL be instantiated once; the FSM, addressing and handshake outputs live in instr_loader.

Verification
REQ-034 Bytes 00,00,FE,12,34,56,78,FF -> one write addr 0 data 32'h12345678, then cpu_start_o one-cycle pulse, load_done_o=1, word_count_o=1.
REQ-035 FE,01,FF,FE,02,FF -> write addr 0 data 32'h01FFFE02, then end; confirms mid-word markers are treated as data.
REQ-036 FE followed by 64 words of 8'hA5 bytes -> 64 writes at addr 0..63, DONE after the 64th write with no end byte, and further bytes ignored.
REQ-037 FE,11,22 then reset pulse, then FE,AA,BB,CC,DD,FF -> a single write addr 0 data 32'hAABBCCDD; no write of 11,22.
REQ-038 With LOADER_CHKSUM_EN: FE,01,02,04,08,FF -> chksum_o=8'h0F; without the macro -> chksum_o=8'h00 throughout.
REQ-039 FF or 00 bytes in IDLE, and FE in DONE -> no writes and no state change.
